// File: rtl/fright_mode_controller.sv
// ============================================================================
// fright_mode_controller
//
// Runs the energizer ("frightened") effect. An energizer pickup opens a
// window that lasts a fixed number of frames. The last part of the window
// drives a white/blue flash. While the window is open, the block tracks which
// ghosts are still blue, accepts ghost-eat events and services them one per
// cycle, lowest ghost index first. When FRIGHT_SCORE_EN is defined it also
// awards the doubling 200/400/800/1600 ghost score chain.
//
// Optional feature macro:
//   FRIGHT_SCORE_EN  - defined  : score chain, ghost_points and points_valid
//                                 are active.
//                      undefined: no chain register is built, and
//                                 ghost_points/points_valid are tied to 0.
//
// Parameters:
//   FRIGHT_FRAMES - window length in frames (must be > FLASH_FRAMES)
//   FLASH_FRAMES  - trailing frames of the window during which flash runs
//   FLASH_PERIOD  - frames per flash half-period (must be >= 1)
//
// Ports:
//   clk           in   system clock
//   resetN        in   asynchronous active-low reset
//   startOfFrame  in   one-cycle pulse per video frame
//   edot_eaten    in   one-cycle pulse, energizer consumed
//   ghost_eaten   in   [3:0] per-ghost one-cycle pulse, Pac-Man touched ghost i
//   level_restart in   synchronous pulse, abort the window immediately
//   frightened    out  high while a window is active
//   flash         out  white/blue alternation select for ghost sprites
//   ghost_blue    out  [3:0] ghost i is currently frightened
//   ghost_points  out  [11:0] score for the ghost just eaten (binary)
//   points_valid  out  one-cycle pulse qualifying ghost_points
// ============================================================================
module fright_mode_controller #(
    parameter int FRIGHT_FRAMES = 360,
    parameter int FLASH_FRAMES  = 120,
    parameter int FLASH_PERIOD  = 15
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        edot_eaten,
    input  logic [3:0]  ghost_eaten,
    input  logic        level_restart,
    output logic        frightened,
    output logic        flash,
    output logic [3:0]  ghost_blue,
    output logic [11:0] ghost_points,
    output logic        points_valid
);

    localparam int RW = $clog2(FRIGHT_FRAMES + 1);
    localparam int FW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

    // The remaining-frame counter is compared before it decrements, so the
    // thresholds are one above the value the tick brings it to.
    localparam logic [RW-1:0] REMAIN_LOAD = RW'(FRIGHT_FRAMES);
    localparam logic [RW-1:0] FLASH_AT    = RW'(FLASH_FRAMES + 1);
    localparam logic [RW-1:0] EXPIRE_AT   = RW'(1);
    localparam logic [FW-1:0] FLASH_WRAP  = FW'(FLASH_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FRIGHT = 2'd1,
        FLASH  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [RW-1:0] remain;
    logic [RW-1:0] remain_next;
    logic [FW-1:0] flash_cnt;
    logic [FW-1:0] flash_cnt_next;
    logic          flash_next;
    logic [3:0]    blue_next;
    logic [3:0]    pending;
    logic [3:0]    pending_next;
    logic [3:0]    request;
    logic [3:0]    lowest;
    logic          tick;
    logic          expire;
    logic          service;

    // Ghost eats are only accepted for ghosts that are still blue. Accepted
    // eats merge with the ghosts already waiting, and the lowest set bit
    // (two's-complement isolation) is the one serviced this cycle.
    assign request = pending | (ghost_eaten & ghost_blue);
    assign lowest  = request & (~request + 4'd1);
    assign tick    = startOfFrame && (state != IDLE);

    // Next-state and datapath. The priority is restart, then a new energizer,
    // then window expiry, then ghost servicing. Servicing still runs on a
    // tick that only moves FRIGHT into FLASH, but an expiring tick drops any
    // waiting ghosts without awarding points.
    always_comb begin
        state_next     = state;
        remain_next    = remain;
        flash_cnt_next = flash_cnt;
        flash_next     = flash;
        blue_next      = ghost_blue;
        pending_next   = pending;
        expire         = 1'b0;
        service        = 1'b0;

        if (level_restart) begin
            state_next     = IDLE;
            remain_next    = '0;
            flash_cnt_next = '0;
            flash_next     = 1'b0;
            blue_next      = 4'b0000;
            pending_next   = 4'b0000;
        end else if (edot_eaten) begin
            state_next     = FRIGHT;
            remain_next    = REMAIN_LOAD;
            flash_cnt_next = '0;
            flash_next     = 1'b0;
            blue_next      = 4'b1111;
            pending_next   = 4'b0000;
        end else begin
            if (tick) begin
                remain_next = remain - 1'b1;
                if (remain == EXPIRE_AT) begin
                    expire         = 1'b1;
                    state_next     = IDLE;
                    flash_cnt_next = '0;
                    flash_next     = 1'b0;
                    blue_next      = 4'b0000;
                    pending_next   = 4'b0000;
                end else if (state == FRIGHT && remain == FLASH_AT) begin
                    state_next     = FLASH;
                    flash_cnt_next = '0;
                    flash_next     = 1'b1;
                end else if (state == FLASH) begin
                    // The half-period counter toggles flash on the tick that wraps it.
                    if (flash_cnt == FLASH_WRAP) begin
                        flash_cnt_next = '0;
                        flash_next     = ~flash;
                    end else begin
                        flash_cnt_next = flash_cnt + 1'b1;
                    end
                end
            end

            if (!expire) begin
                service      = |request;
                blue_next    = ghost_blue & ~lowest;
                pending_next = request & ~lowest;
            end
        end
    end

    // The window registers. frightened is registered from the next state, so
    // it rises together with ghost_blue on the cycle after the energizer.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            remain     <= '0;
            flash_cnt  <= '0;
            flash      <= 1'b0;
            ghost_blue <= 4'b0000;
            pending    <= 4'b0000;
            frightened <= 1'b0;
        end else begin
            state      <= state_next;
            remain     <= remain_next;
            flash_cnt  <= flash_cnt_next;
            flash      <= flash_next;
            ghost_blue <= blue_next;
            pending    <= pending_next;
            frightened <= (state_next != IDLE);
        end
    end

`ifdef FRIGHT_SCORE_EN
    logic [11:0] chain;
    logic [11:0] chain_doubled;

    // Doubling score chain, saturating at 1600.
    assign chain_doubled = (chain >= 12'd1600) ? 12'd1600 : {chain[10:0], 1'b0};

    // Each serviced ghost presents the current chain value and then doubles
    // it. A new energizer restarts the chain at 200. ghost_points holds its
    // last value between awards.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            chain        <= 12'd200;
            ghost_points <= 12'd0;
            points_valid <= 1'b0;
        end else if (level_restart) begin
            chain        <= 12'd200;
            ghost_points <= 12'd0;
            points_valid <= 1'b0;
        end else begin
            points_valid <= service;
            if (edot_eaten) begin
                chain <= 12'd200;
            end else if (service) begin
                ghost_points <= chain;
                chain        <= chain_doubled;
            end
        end
    end
`else
    logic unused_service;

    assign unused_service = service;
    assign ghost_points   = 12'd0;
    assign points_valid   = 1'b0;
`endif

endmodule
